// File: rtl/int_trigger_seq.sv
// int_trigger_seq: walks a PC-trigger table and raises CPU interrupt lines until acknowledged.
// Optional feature macro: INT_TRIG_REPEAT_EN (loop the table instead of stopping in DONE).
module int_trigger_seq #(
  parameter int          N_TRIG   = 16,
  parameter int          N_CH     = 6,
  parameter logic [31:0] ACK_BASE = 32'h7f20,
  parameter int          ACK_STEP = 4,
  localparam int         IDX_W    = $clog2(N_TRIG),
  localparam int         CH_W     = (N_CH > 2) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic [31:0]      cfg_pc,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic             cfg_last,
  input  logic [31:0]      macroscopic_pc,
  input  logic [31:0]      m_int_addr,
  input  logic [3:0]       m_int_byteen,
  output logic [N_CH-1:0]  interrupt,
  output logic [IDX_W-1:0] cur_idx,
  output logic             busy,
  output logic             done,
  output logic [15:0]      fire_cnt
);

  localparam int CH_N = 1 << CH_W;

  typedef enum logic [1:0] {IDLE, ARMED, DONE} state_e;

  state_e            state_q, state_d;
  logic [31:0]       tblPc_q [N_TRIG];
  logic [CH_W-1:0]   tblCh_q [N_TRIG];
  logic [N_TRIG-1:0] tblLast_q, tblValid_q;
  logic [N_CH-1:0]   int_q, int_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [15:0]       cnt_q, cnt_d;

  logic [N_CH-1:0]   ack;
  logic [CH_N-1:0]   intWide, ackWide;
  logic [CH_W-1:0]   entCh;
  logic              entLast, entValid, match, fire;

  always_comb begin
    ack = '0;
    for (int k = 0; k < N_CH; k++) begin
      ack[k] = (|m_int_byteen) &&
               ((m_int_addr & ~32'h3) == ACK_BASE + 32'(k * ACK_STEP));
    end
  end

  // Channel codes beyond N_CH read as an idle, never-acknowledged line.
  always_comb begin
    intWide = '0;
    ackWide = '0;
    intWide[N_CH-1:0] = int_q;
    ackWide[N_CH-1:0] = ack;
  end

  assign entValid = tblValid_q[idx_q];
  assign entLast  = tblLast_q[idx_q];
  assign entCh    = tblCh_q[idx_q];
  assign match    = entValid && ((macroscopic_pc & ~32'h3) == tblPc_q[idx_q]);
  assign fire     = (state_q == ARMED) && en && match &&
                    (!intWide[entCh] || ackWide[entCh]);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    int_d   = int_q & ~ack;
    unique case (state_q)
      IDLE: if (en) state_d = ARMED;
      ARMED: begin
        if (!en) begin
          state_d = IDLE;
        end else if (!entValid) begin
          state_d = DONE;
        end else if (fire) begin
          if (cnt_q != 16'hffff) cnt_d = cnt_q + 16'd1;
          if (entLast || idx_q == IDX_W'(N_TRIG - 1)) begin
`ifdef INT_TRIG_REPEAT_EN
            idx_d = '0;
`else
            state_d = DONE;
`endif
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: ;
    endcase
    // Set is applied after the ack clear so it wins on the same channel.
    for (int k = 0; k < N_CH; k++) begin
      if (fire && entCh == CH_W'(k)) int_d[k] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      int_q      <= '0;
      tblValid_q <= '0;
      tblLast_q  <= '0;
      for (int i = 0; i < N_TRIG; i++) begin
        tblPc_q[i] <= '0;
        tblCh_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      int_q   <= int_d;
      if (cfg_we) begin
        tblPc_q[cfg_idx]    <= cfg_pc & ~32'h3;
        tblCh_q[cfg_idx]    <= cfg_ch;
        tblLast_q[cfg_idx]  <= cfg_last;
        tblValid_q[cfg_idx] <= 1'b1;
      end
    end
  end

  assign interrupt = int_q;
  assign cur_idx   = idx_q;
  assign busy      = (state_q == ARMED);
  assign done      = (state_q == DONE);
  assign fire_cnt  = cnt_q;

endmodule

// File: tb/tb_int_trigger_seq.sv
// tb_int_trigger_seq: scoreboard bench for int_trigger_seq with a behavioural table/sequence model.
// Honours INT_TRIG_REPEAT_EN the same way the design does.
module tb_int_trigger_seq;

  localparam int          N_TRIG   = 16;
  localparam int          N_CH     = 6;
  localparam logic [31:0] ACK_BASE = 32'h7f20;
  localparam int          ACK_STEP = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0;
  logic        cfg_we = 1'b0;
  logic [3:0]  cfg_idx = '0;
  logic [31:0] cfg_pc = '0;
  logic [2:0]  cfg_ch = '0;
  logic        cfg_last = 1'b0;
  logic [31:0] macroscopic_pc = '0;
  logic [31:0] m_int_addr = '0;
  logic [3:0]  m_int_byteen = '0;
  logic [N_CH-1:0] interrupt;
  logic [3:0]  cur_idx;
  logic        busy, done;
  logic [15:0] fire_cnt;

  int checks = 0;
  int errors = 0;

  int_trigger_seq #(.N_TRIG(N_TRIG), .N_CH(N_CH), .ACK_BASE(ACK_BASE), .ACK_STEP(ACK_STEP)) dut (
    .clk(clk), .reset(reset), .en(en), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_pc(cfg_pc), .cfg_ch(cfg_ch), .cfg_last(cfg_last),
    .macroscopic_pc(macroscopic_pc), .m_int_addr(m_int_addr), .m_int_byteen(m_int_byteen),
    .interrupt(interrupt), .cur_idx(cur_idx), .busy(busy), .done(done), .fire_cnt(fire_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          we;
    int          idx;
    logic [31:0] pc;
    int          ch;
    bit          last;
    bit          en;
    logic [31:0] mpc;
    logic [31:0] addr;
    logic [3:0]  be;
  } stim_t;

  typedef struct {
    logic [N_CH-1:0] intr;
    int              idx;
    bit              busy;
    bit              done;
    int              cnt;
  } exp_t;

  exp_t expQ[$];

  // Reference model: trigger table plus "running"/"finished" flags of the sequence.
  logic [31:0]     tPc [N_TRIG];
  int              tCh [N_TRIG];
  bit              tLast [N_TRIG];
  bit              tValid [N_TRIG];
  bit              mRun, mFin;
  int              mIdx, mCnt;
  logic [N_CH-1:0] mIntr;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got=%0h expected=%0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < N_TRIG; i++) begin
      tPc[i] = '0; tCh[i] = 0; tLast[i] = 0; tValid[i] = 0;
    end
    mRun = 0; mFin = 0; mIdx = 0; mCnt = 0; mIntr = '0;
  endtask

  task automatic modelStep(input stim_t s);
    logic [N_CH-1:0] ackV;
    logic [N_CH-1:0] nextIntr;
    int ch;
    ackV = '0;
    for (int k = 0; k < N_CH; k++)
      ackV[k] = (s.be != 4'h0) && ((s.addr & ~32'h3) == ACK_BASE + 32'(k * ACK_STEP));
    nextIntr = mIntr & ~ackV;
    ch = tCh[mIdx];
    if (mRun) begin
      if (!s.en) begin
        mRun = 0;
      end else if (!tValid[mIdx]) begin
        mRun = 0;
        mFin = 1;
      end else if ((s.mpc & ~32'h3) == tPc[mIdx] && (!mIntr[ch] || ackV[ch])) begin
        nextIntr[ch] = 1'b1;
        if (mCnt < 65535) mCnt++;
        if (tLast[mIdx] || mIdx == N_TRIG - 1) begin
`ifdef INT_TRIG_REPEAT_EN
          mIdx = 0;
`else
          mRun = 0;
          mFin = 1;
`endif
        end else begin
          mIdx++;
        end
      end
    end else if (!mFin && s.en) begin
      mRun = 1;
    end
    mIntr = nextIntr;
    if (s.we) begin
      tPc[s.idx] = s.pc & ~32'h3; tCh[s.idx] = s.ch; tLast[s.idx] = s.last; tValid[s.idx] = 1;
    end
  endtask

  task automatic pushExpected();
    exp_t e;
    e.intr = mIntr; e.idx = mIdx; e.busy = mRun; e.done = mFin; e.cnt = mCnt;
    expQ.push_back(e);
  endtask

  task automatic applyStimulus(input stim_t s);
    @(negedge clk); #1;
    reset          = 1'b0;
    cfg_we         = s.we;
    cfg_idx        = 4'(s.idx);
    cfg_pc         = s.pc;
    cfg_ch         = 3'(s.ch);
    cfg_last       = s.last;
    en             = s.en;
    macroscopic_pc = s.mpc;
    m_int_addr     = s.addr;
    m_int_byteen   = s.be;
    modelStep(s);
    pushExpected();
  endtask

  // Reset is raised between edges so the asynchronous clear can be seen directly.
  task automatic applyReset();
    @(negedge clk); #1;
    cfg_we = 1'b0; en = 1'b0; m_int_byteen = '0;
    reset = 1'b1;
    #1;
    checkOutput("asyncIntr", 32'(interrupt), 32'h0);
    checkOutput("asyncIdx", 32'(cur_idx), 32'h0);
    checkOutput("asyncBusy", 32'(busy), 32'h0);
    checkOutput("asyncDone", 32'(done), 32'h0);
    checkOutput("asyncCnt", 32'(fire_cnt), 32'h0);
    modelReset();
    pushExpected();
  endtask

  task automatic cyc(input bit e, input logic [31:0] mpc, input logic [31:0] addr, input logic [3:0] be);
    stim_t s;
    s = '{default: 0};
    s.en = e; s.mpc = mpc; s.addr = addr; s.be = be;
    applyStimulus(s);
  endtask

  task automatic cfgWrite(input int idx, input logic [31:0] pc, input int ch, input bit last);
    stim_t s;
    s = '{default: 0};
    s.we = 1; s.idx = idx; s.pc = pc; s.ch = ch; s.last = last;
    applyStimulus(s);
  endtask

  // Monitor: every falling edge shows the response to the inputs of the preceding rising edge.
  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      exp_t e;
      e = expQ.pop_front();
      checkOutput("interrupt", 32'(interrupt), 32'(e.intr));
      checkOutput("cur_idx", 32'(cur_idx), 32'(e.idx[3:0]));
      checkOutput("busy", 32'(busy), 32'(e.busy));
      checkOutput("done", 32'(done), 32'(e.done));
      checkOutput("fire_cnt", 32'(fire_cnt), 32'(e.cnt));
    end
  end

  initial begin
    stim_t s;
    $display("[TB] int_trigger_seq bench start");
    applyReset();

    // Single fire then acknowledge.
    cfgWrite(0, 32'h3010, 0, 1);
    cyc(1, 32'h0, 32'h0, 4'h0);
    cyc(1, 32'h3010, 32'h0, 4'h0);
    cyc(1, 32'h0, 32'h7f20, 4'hf);
    checkOutput("t1Intr", 32'(interrupt), 32'h01);
    cyc(1, 32'h0, 32'h0, 4'h0);
    checkOutput("t1Cleared", 32'(interrupt), 32'h00);
`ifndef INT_TRIG_REPEAT_EN
    checkOutput("t1Done", 32'(done), 32'h1);
`endif
    checkOutput("t1Cnt", 32'(fire_cnt), 32'h1);

    // Two channels, acknowledged separately.
    applyReset();
    cfgWrite(0, 32'h3014, 2, 0);
    cfgWrite(1, 32'h3018, 5, 1);
    cyc(1, 32'h0, 32'h0, 4'h0);
    cyc(1, 32'h3014, 32'h0, 4'h0);
    cyc(1, 32'h3018, 32'h0, 4'h0);
    cyc(1, 32'h0, 32'h7f28, 4'hf);
    checkOutput("t2Both", 32'(interrupt), 32'h24);
    cyc(1, 32'h0, 32'h7f34, 4'hf);
    checkOutput("t2Ch5", 32'(interrupt), 32'h20);
    cyc(1, 32'h0, 32'h0, 4'h0);
    checkOutput("t2None", 32'(interrupt), 32'h00);

    // Hold on a busy line, then ack and re-fire in the same cycle.
    applyReset();
    cfgWrite(0, 32'h3020, 1, 0);
    cfgWrite(1, 32'h3024, 1, 1);
    cyc(1, 32'h0, 32'h0, 4'h0);
    cyc(1, 32'h3020, 32'h0, 4'h0);
    cyc(1, 32'h3024, 32'h0, 4'h0);
    cyc(1, 32'h3024, 32'h0, 4'h0);
    cyc(1, 32'h3024, 32'h7f24, 4'hf);
    checkOutput("t3HoldIdx", 32'(cur_idx), 32'h1);
    checkOutput("t3HoldCnt", 32'(fire_cnt), 32'h1);
    cyc(1, 32'h0, 32'h0, 4'h0);
    checkOutput("t3Line", 32'(interrupt), 32'h02);
    checkOutput("t3Cnt", 32'(fire_cnt), 32'h2);
`ifndef INT_TRIG_REPEAT_EN
    checkOutput("t3Done", 32'(done), 32'h1);
`endif

    // Misaligned PC and ack address, zero byte enables.
    applyReset();
    cfgWrite(0, 32'h3010, 0, 0);
    cyc(1, 32'h0, 32'h0, 4'h0);
    cyc(1, 32'h3011, 32'h0, 4'h0);
    cyc(1, 32'h0, 32'h7f20, 4'h0);
    checkOutput("t4Fired", 32'(interrupt), 32'h01);
    cyc(1, 32'h0, 32'h7f22, 4'h2);
    checkOutput("t4ZeroBe", 32'(interrupt), 32'h01);
    cyc(1, 32'h0, 32'h0, 4'h0);
    checkOutput("t4Cleared", 32'(interrupt), 32'h00);

    // Reset in the middle of a sequence wipes the table.
    applyReset();
    for (int i = 0; i < 4; i++) cfgWrite(i, 32'h3000 + 32'(4 * i), 1, 0);
    cyc(1, 32'h0, 32'h0, 4'h0);
    cyc(1, 32'h3000, 32'h0, 4'h0);
    cyc(1, 32'h3004, 32'h7f24, 4'hf);
    cyc(1, 32'h3008, 32'h7f24, 4'hf);
    cyc(1, 32'h0, 32'h0, 4'h0);
    checkOutput("t5Intr", 32'(interrupt), 32'h02);
    checkOutput("t5Idx", 32'(cur_idx), 32'h3);
    applyReset();
    cyc(1, 32'h0, 32'h0, 4'h0);
    cyc(1, 32'h0, 32'h0, 4'h0);
    checkOutput("t5Armed", 32'(busy), 32'h1);
    cyc(1, 32'h0, 32'h0, 4'h0);
    checkOutput("t5EmptyDone", 32'(done), 32'h1);

`ifdef INT_TRIG_REPEAT_EN
    // Looping single-entry sequence.
    applyReset();
    cfgWrite(0, 32'h3010, 0, 1);
    cyc(1, 32'h0, 32'h0, 4'h0);
    cyc(1, 32'h3010, 32'h0, 4'h0);
    cyc(1, 32'h0, 32'h7f20, 4'hf);
    cyc(1, 32'h3010, 32'h0, 4'h0);
    cyc(1, 32'h0, 32'h0, 4'h0);
    checkOutput("t6Cnt", 32'(fire_cnt), 32'h2);
    checkOutput("t6Busy", 32'(busy), 32'h1);
`endif

    // Randomized traffic over a small PC window so matches and acks are frequent.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 149) == 0) begin
        applyReset();
      end else begin
        s = '{default: 0};
        s.we   = ($urandom_range(0, 3) == 0);
        s.idx  = $urandom_range(0, N_TRIG - 1);
        s.pc   = 32'h3000 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
        s.ch   = $urandom_range(0, N_CH - 1);
        s.last = ($urandom_range(0, 5) == 0);
        s.en   = ($urandom_range(0, 15) != 0);
        s.mpc  = 32'h3000 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
        if ($urandom_range(0, 2) != 0)
          s.addr = ACK_BASE + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
        else
          s.addr = $urandom;
        s.be   = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
        applyStimulus(s);
      end
    end

    @(negedge clk);
    @(negedge clk);
    checkOutput("queueDrained", 32'(expQ.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
